pc_ctrl: RTL

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Brief    : PC sequencing FSM driving fetch requests and counter enable/load.
// Revision : 1.0  initial release
// ============================================================================
module pc_ctrl #(
    parameter int DATAWIDTH  = 5,
    parameter int UPPERLIMIT = 28
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 br_req,
    input  logic [DATAWIDTH-1:0] br_target,
    input  logic [DATAWIDTH-1:0] pc_value,
    input  logic                 imem_ready,
    output logic                 imem_req,
    output logic                 pc_en,
    output logic                 pc_load,
    output logic [DATAWIDTH-1:0] pc_data,
    output logic                 busy,
    output logic                 wrap,
    output logic                 err
);

    localparam logic [DATAWIDTH-1:0] LIMIT = DATAWIDTH'(UPPERLIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_ADV    = 3'd2,
        S_REDIR  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   pend_q, pend_d;
    logic [DATAWIDTH-1:0]   tgt_q, tgt_d;
    logic                   err_d;
    logic                   active_w;
    logic                   br_ok_w;
    logic                   br_bad_w;

    assign active_w = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign br_ok_w  = br_req && active_w && (br_target <= LIMIT);
    assign br_bad_w = br_req && active_w && (br_target > LIMIT);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        err_d   = err | br_bad_w;

        if (state_q == S_REDIR)
            pend_d = 1'b0;
        // A fresh request beats the clear in REDIR and overwrites any unserviced one
        if (br_ok_w) begin
            pend_d = 1'b1;
            tgt_d  = br_target;
        end

        case (state_q)
            S_IDLE:   if (start) state_d = S_REQ;
            S_REQ: begin
                if (halt)
                    state_d = S_HALTED;
                else if (pend_q || br_ok_w)
                    state_d = S_REDIR;
                else if (imem_ready && !stall)
                    state_d = S_ADV;
            end
            S_ADV:    state_d = S_REQ;
            S_REDIR:  state_d = S_REQ;
            S_HALTED: if (start && !halt) state_d = S_REQ;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_HALTED)
            pend_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
            imem_req <= 1'b0;
            pc_en    <= 1'b0;
            pc_load  <= 1'b0;
            pc_data  <= '0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
            imem_req <= (state_d == S_REQ);
            pc_en    <= (state_d == S_ADV);
            pc_load  <= (state_d == S_REDIR);
            pc_data  <= (state_d == S_REDIR) ? tgt_d : '0;
            busy     <= (state_d != S_IDLE) && (state_d != S_HALTED);
            // pc_value holds steady until pc_en fires, so the REQ-cycle value is the ADV value
            wrap     <= (state_d == S_ADV) && (pc_value == LIMIT);
            err      <= err_d;
        end
    end

endmodule
`default_nettype wire
